// File: rtl/aes_decrypt_core_if.sv
// Request/result bundle between a client and the AES-128 decryption core.
// start is taken on a rising edge only while ready is high; done pulses one cycle with out valid.
interface aes_decrypt_core_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] in;
    logic         ready;
    logic         done;
    logic [127:0] out;
    logic [2:0]   dbg_state;

    modport master (output start, key, in, input ready, done, out, dbg_state);
    modport slave  (input start, key, in, output ready, done, out, dbg_state);
endinterface

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption: forward key expansion to rk10, then one inverse
// round per clock while the round key is walked backwards on the fly.
module aes_decrypt_core (
    input  logic              clk,
    input  logic              rst,
    aes_decrypt_core_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL} state_t;

    localparam logic [0:2047] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] INV_SBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] md(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] me(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Row r of each column comes from column (c - r) mod 4, then goes through the inverse S-box.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] r;
        int           src;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            src = (b % 4) + 4 * (((b / 4) - (b % 4) + 4) % 4);
            r[127 - 8*b -: 8] = inv_sbox(s[127 - 8*src -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
            r[119 - 32*c -: 8] = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
            r[111 - 32*c -: 8] = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
            r[103 - 32*c -: 8] = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(i), 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one schedule step: rk_i -> rk_{i-1}, recovering w3 first since SubWord needs it.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rcon(i), 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    state_t       r_fsm, w_next;
    logic [127:0] r_data, r_key, r_out;
    logic [3:0]   r_rc;
    logic         r_done;
    logic [127:0] w_key_fwd, w_key_inv, w_sub, w_round;

    assign w_key_fwd     = key_fwd(r_key, r_rc);
    assign w_key_inv     = key_inv(r_key, r_rc);
    assign w_sub         = inv_shift_sub(r_data) ^ r_key;
    assign w_round       = inv_mix_columns(w_sub);
    assign bus.done      = r_done;
    assign bus.out       = r_out;
    assign bus.dbg_state = r_fsm;

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_next;
    end

    always_comb begin
        w_next    = r_fsm;
        bus.ready = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) w_next = S_KEYEXP;
            end
            S_KEYEXP: if (r_rc == 4'd10) w_next = S_INIT;
            S_INIT:   w_next = S_ROUND;
            S_ROUND:  if (r_rc == 4'd1) w_next = S_FINAL;
            S_FINAL:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // rc parks at 10 after expansion so INIT steps back with Rcon[10].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_key  <= '0;
            r_out  <= '0;
            r_rc   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_fsm == S_FINAL);
            case (r_fsm)
                S_IDLE: begin
                    if (bus.start) begin
                        r_data <= bus.in;
                        r_key  <= bus.key;
                        r_rc   <= 4'd1;
                    end
                end
                S_KEYEXP: begin
                    r_key <= w_key_fwd;
                    r_rc  <= (r_rc == 4'd10) ? 4'd10 : r_rc + 4'd1;
                end
                S_INIT: begin
                    r_data <= r_data ^ r_key;
                    r_key  <= w_key_inv;
                    r_rc   <= 4'd9;
                end
                S_ROUND: begin
                    r_data <= w_round;
                    r_key  <= w_key_inv;
                    r_rc   <= r_rc - 4'd1;
                end
                S_FINAL: r_out <= w_sub;
                default: ;
            endcase
        end
    end
endmodule
